matrix_pixel_fetch: RTL and testbench

// - Feeds colour data to the HUB75 shift chain driven by matrix_scan: per pixel-load cycle, reads top/bottom half pixels (RGB565) from a double-buffered framebuffer RAM.
// - Selects the bit for the current brightness plane and outputs rgb_top/rgb_bot.
// - Owns the framebuffer bank swap, applied only at a frame boundary, so the writer never tears the displayed frame.

---
 rtl/matrix_pixel_fetch.sv | 176 +++++++++++++++++
 tb/tb_matrix_pixel_fetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_pixel_fetch.sv
// HUB75 pixel fetch: reads top/bottom RGB565 pixels from a double-buffered framebuffer and emits
// the current brightness-plane bits. Define MATRIX_FETCH_GAMMA_EN to add a registered gamma stage.
module matrix_pixel_fetch #(
  parameter int COL_WIDTH    = 6,
  parameter int ROW_WIDTH    = 4,
  parameter int BRIGHT_WIDTH = 6
) (
  input  logic                               clk_in,
  input  logic                               reset,
  input  logic                               pixel_load_en,
  input  logic [COL_WIDTH-1:0]               column_address,
  input  logic [ROW_WIDTH-1:0]               row_address,
  input  logic [BRIGHT_WIDTH-1:0]            brightness_mask,
  output logic [COL_WIDTH+ROW_WIDTH+1:0]     ram_rd_addr_top,
  output logic [COL_WIDTH+ROW_WIDTH+1:0]     ram_rd_addr_bot,
  input  logic [15:0]                        ram_rd_data_top,
  input  logic [15:0]                        ram_rd_data_bot,
  output logic [2:0]                         rgb_top,
  output logic [2:0]                         rgb_bot,
  output logic                               rgb_valid,
  input  logic                               swap_req,
  output logic                               swap_ack,
  output logic                               display_bank
);

  typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;

  state_t                            state_q, state_d;
  logic                              bank_q, bank_d;
  logic                              ack_q, ack_d;
  logic                              fb;
  logic [COL_WIDTH+ROW_WIDTH+1:0]    addr_top_q, addr_bot_q;
  logic                              vld_p0_q, vld_p1_q;
  logic [BRIGHT_WIDTH-1:0]           mask_p0_q, mask_p1_q;
  logic [2:0]                        rgb_top_q, rgb_bot_q;
  logic                              rgb_valid_q;
  logic [17:0]                       px_top_fin, px_bot_fin;
  logic [BRIGHT_WIDTH-1:0]           mask_fin;
  logic                              vld_fin;

  // Widen RGB565 to three 6-bit channels, replicating the MSB into the new LSB of R and B.
  function automatic logic [17:0] expand565(input logic [15:0] p);
    return {p[15:11], p[15], p[10:5], p[4:0], p[4]};
  endfunction

  function automatic logic [2:0] plane3(input logic [17:0] px, input logic [BRIGHT_WIDTH-1:0] m);
    return {|(px[17:12] & m), |(px[11:6] & m), |(px[5:0] & m)};
  endfunction

`ifdef MATRIX_FETCH_GAMMA_EN
  logic                              vld_p2_q;
  logic [BRIGHT_WIDTH-1:0]           mask_p2_q;
  logic [17:0]                       px_top_p2_q, px_bot_p2_q;

  function automatic logic [5:0] gamma6(input logic [5:0] c);
    logic [11:0] sq;
    sq = 12'(c) * 12'(c) + 12'(c);
    return sq[11:6];
  endfunction

  function automatic logic [17:0] gamma18(input logic [17:0] px);
    return {gamma6(px[17:12]), gamma6(px[11:6]), gamma6(px[5:0])};
  endfunction
`endif

  // Last fetch of the last row on plane 0 closes the frame.
  assign fb = pixel_load_en
           && (column_address == {COL_WIDTH{1'b1}})
           && (row_address == {ROW_WIDTH{1'b1}})
           && (brightness_mask == BRIGHT_WIDTH'(1));

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bank_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (swap_req) state_d = fb ? DONE : PEND;
      PEND:    if (!swap_req) state_d = IDLE;
               else if (fb) state_d = DONE;
      DONE:    if (!swap_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The FB pixel is addressed from the old bank; the toggle lands on the same edge.
  always_comb begin
    ack_d  = (state_q != DONE) && swap_req && fb;
    bank_d = bank_q ^ ack_d;
  end

  // Stage S0: address, mask and valid capture
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      addr_top_q <= '0;
      addr_bot_q <= '0;
      vld_p0_q   <= 1'b0;
      mask_p0_q  <= '0;
      vld_p1_q   <= 1'b0;
      mask_p1_q  <= '0;
`ifdef MATRIX_FETCH_GAMMA_EN
      vld_p2_q   <= 1'b0;
      mask_p2_q  <= '0;
`endif
    end else begin
      vld_p0_q <= pixel_load_en;
      if (pixel_load_en) begin
        addr_top_q <= {bank_q, 1'b0, row_address, column_address};
        addr_bot_q <= {bank_q, 1'b1, row_address, column_address};
        mask_p0_q  <= brightness_mask;
      end
      // Stage S1: RAM read in flight
      vld_p1_q  <= vld_p0_q;
      mask_p1_q <= mask_p0_q;
`ifdef MATRIX_FETCH_GAMMA_EN
      // Stage S2: gamma LUT registered
      vld_p2_q  <= vld_p1_q;
      mask_p2_q <= mask_p1_q;
`endif
    end
  end

`ifdef MATRIX_FETCH_GAMMA_EN
  always_ff @(posedge clk_in) begin
    px_top_p2_q <= gamma18(expand565(ram_rd_data_top));
    px_bot_p2_q <= gamma18(expand565(ram_rd_data_bot));
  end

  always_comb begin
    px_top_fin = px_top_p2_q;
    px_bot_fin = px_bot_p2_q;
    mask_fin   = mask_p2_q;
    vld_fin    = vld_p2_q;
  end
`else
  always_comb begin
    px_top_fin = expand565(ram_rd_data_top);
    px_bot_fin = expand565(ram_rd_data_bot);
    mask_fin   = mask_p1_q;
    vld_fin    = vld_p1_q;
  end
`endif

  // Output stage: plane select; colour bits hold between fetches
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rgb_top_q   <= 3'b000;
      rgb_bot_q   <= 3'b000;
      rgb_valid_q <= 1'b0;
    end else begin
      rgb_valid_q <= vld_fin;
      if (vld_fin) begin
        rgb_top_q <= plane3(px_top_fin, mask_fin);
        rgb_bot_q <= plane3(px_bot_fin, mask_fin);
      end
    end
  end

  assign ram_rd_addr_top = addr_top_q;
  assign ram_rd_addr_bot = addr_bot_q;
  assign rgb_top         = rgb_top_q;
  assign rgb_bot         = rgb_bot_q;
  assign rgb_valid       = rgb_valid_q;
  assign swap_ack        = ack_q;
  assign display_bank    = bank_q;

endmodule

// File: tb/tb_matrix_pixel_fetch.sv
// Randomized bench for matrix_pixel_fetch with a framebuffer RAM model and a queue-based reference.
module tb_matrix_pixel_fetch;
`ifdef MATRIX_FETCH_GAMMA_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk_in = 1'b0;
  logic        reset;
  logic        pixel_load_en;
  logic [5:0]  column_address;
  logic [3:0]  row_address;
  logic [5:0]  brightness_mask;
  logic [11:0] ram_rd_addr_top, ram_rd_addr_bot;
  logic [15:0] ram_rd_data_top, ram_rd_data_bot;
  logic [2:0]  rgb_top, rgb_bot;
  logic        rgb_valid;
  logic        swap_req;
  logic        swap_ack;
  logic        display_bank;

  matrix_pixel_fetch dut (
    .clk_in(clk_in), .reset(reset), .pixel_load_en(pixel_load_en),
    .column_address(column_address), .row_address(row_address),
    .brightness_mask(brightness_mask),
    .ram_rd_addr_top(ram_rd_addr_top), .ram_rd_addr_bot(ram_rd_addr_bot),
    .ram_rd_data_top(ram_rd_data_top), .ram_rd_data_bot(ram_rd_data_bot),
    .rgb_top(rgb_top), .rgb_bot(rgb_bot), .rgb_valid(rgb_valid),
    .swap_req(swap_req), .swap_ack(swap_ack), .display_bank(display_bank)
  );

  always #5 clk_in = ~clk_in;

  logic [15:0] mem [0:4095];
  always @(posedge clk_in) begin
    ram_rd_data_top <= mem[ram_rd_addr_top];
    ram_rd_data_bot <= mem[ram_rd_addr_bot];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  logic        m_bank, m_served, m_ack;
  logic [11:0] m_addr_t, m_addr_b;
  logic [2:0]  m_last_t, m_last_b;
  logic        m_vld;
  logic [6:0]  pipe [$];
  int          vcount;

  function automatic int chan_map(input int c);
`ifdef MATRIX_FETCH_GAMMA_EN
    return (c * c + c) / 64;
`else
    return c;
`endif
  endfunction

  function automatic logic [2:0] ref_pix(input logic [15:0] p, input logic [5:0] m);
    int r5, g6, b5, r6, b6;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    r6 = chan_map(r5 * 2 + r5 / 16);
    g6 = chan_map(g6);
    b6 = chan_map(b5 * 2 + b5 / 16);
    return {(r6 & int'(m)) != 0, (g6 & int'(m)) != 0, (b6 & int'(m)) != 0};
  endfunction

  task automatic model_reset();
    m_bank = 1'b0; m_served = 1'b0; m_ack = 1'b0;
    m_addr_t = '0; m_addr_b = '0;
    m_last_t = '0; m_last_b = '0; m_vld = 1'b0;
    pipe.delete();
  endtask

  task automatic check_all();
    chk("rgb_valid", 32'(rgb_valid), 32'(m_vld));
    chk("rgb_top", 32'(rgb_top), 32'(m_last_t));
    chk("rgb_bot", 32'(rgb_bot), 32'(m_last_b));
    chk("display_bank", 32'(display_bank), 32'(m_bank));
    chk("swap_ack", 32'(swap_ack), 32'(m_ack));
    chk("addr_top", 32'(ram_rd_addr_top), 32'(m_addr_t));
    chk("addr_bot", 32'(ram_rd_addr_bot), 32'(m_addr_b));
  endtask

  task automatic cyc(input logic ld, input int col, input int row, input logic [5:0] m,
                     input logic req);
    logic       fb, do_swap;
    logic [11:0] at, ab;
    logic [6:0] e, ev;
    pixel_load_en = ld; column_address = col[5:0]; row_address = row[3:0];
    brightness_mask = m; swap_req = req;
    fb = ld && (col == 63) && (row == 15) && (m == 6'b000001);
    do_swap = req && !m_served && fb;
    at = {m_bank, 1'b0, row[3:0], col[5:0]};
    ab = {m_bank, 1'b1, row[3:0], col[5:0]};
    e = '0;
    if (ld) begin
      e = {1'b1, ref_pix(mem[at], m), ref_pix(mem[ab], m)};
      m_addr_t = at; m_addr_b = ab;
    end
    @(posedge clk_in);
    if (do_swap) begin m_bank = ~m_bank; m_served = 1'b1; end
    if (!req) m_served = 1'b0;
    m_ack = do_swap;
    pipe.push_back(e);
    ev = '0;
    if (pipe.size() > LAT) ev = pipe.pop_front();
    m_vld = ev[6];
    if (ev[6]) begin m_last_t = ev[5:3]; m_last_b = ev[2:0]; end
    #1;
    check_all();
    if (rgb_valid) vcount++;
  endtask

  task automatic idle(input int n, input logic req);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 6'b0, req);
  endtask

  task automatic do_reset(input int n);
    pixel_load_en = 1'b0; swap_req = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in); #1;
      check_all();
    end
    reset = 1'b1;
  endtask

  initial begin
    logic req_r;
    logic [5:0] msk;
    int col, row;
    reset = 1'b1; pixel_load_en = 1'b0; swap_req = 1'b0;
    column_address = '0; row_address = '0; brightness_mask = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    mem[12'h03F] = 16'hF800;
    mem[12'h43F] = 16'h001F;
    mem[12'h045] = 16'h0400;
    #2;
    do_reset(3);
    idle(6, 1'b0);

    // Pure red over pure blue on the MSB plane
    cyc(1'b1, 63, 0, 6'b100000, 1'b0);
    idle(LAT, 1'b0);
    chk("red_top", 32'(rgb_top), 32'h4);
    chk("blue_bot", 32'(rgb_bot), 32'h1);
    chk("red_valid", 32'(rgb_valid), 32'h1);
    idle(2, 1'b0);

    // Green mid-level across two planes
    cyc(1'b1, 5, 1, 6'b100000, 1'b0);
    cyc(1'b1, 5, 1, 6'b010000, 1'b0);
    idle(LAT - 1, 1'b0);
`ifdef MATRIX_FETCH_GAMMA_EN
    chk("green_plane5", 32'(rgb_top[1]), 32'h0);
    idle(1, 1'b0);
    chk("green_plane4", 32'(rgb_top[1]), 32'h1);
`else
    chk("green_plane5", 32'(rgb_top[1]), 32'h1);
    idle(1, 1'b0);
    chk("green_plane4", 32'(rgb_top[1]), 32'h0);
`endif
    idle(LAT + 1, 1'b0);

    // A full row streamed back to back
    vcount = 0;
    for (int c = 63; c >= 0; c--) cyc(1'b1, c, 2, 6'(1 << $urandom_range(0, 5)), 1'b0);
    idle(LAT + 3, 1'b0);
    chk("row_valid_count", 32'(vcount), 32'd64);

    // Swap request waits for the frame boundary, then applies once
    for (int i = 0; i < 10; i++) cyc(1'b1, $urandom_range(0, 63), 5, 6'b000001, 1'b1);
    chk("no_early_swap", 32'(display_bank), 32'h0);
    cyc(1'b1, 63, 15, 6'b000001, 1'b1);
    chk("swap_bank", 32'(display_bank), 32'h1);
    chk("swap_ack_pulse", 32'(swap_ack), 32'h1);
    cyc(1'b1, 7, 3, 6'b000100, 1'b1);
    chk("next_fetch_bank", 32'(ram_rd_addr_top[11]), 32'h1);
    chk("ack_one_cycle", 32'(swap_ack), 32'h0);
    for (int i = 0; i < 5; i++) cyc(1'b1, $urandom_range(0, 63), 9, 6'b000010, 1'b1);
    cyc(1'b1, 63, 15, 6'b000001, 1'b1);
    idle(1, 1'b1);
    chk("no_second_swap", 32'(display_bank), 32'h1);
    idle(2, 1'b0);

    // Request withdrawn before the boundary
    for (int i = 0; i < 3; i++) cyc(1'b1, $urandom_range(0, 62), 15, 6'b000001, 1'b1);
    cyc(1'b0, 0, 0, 6'b0, 1'b0);
    cyc(1'b1, 63, 15, 6'b000001, 1'b0);
    chk("withdrawn_bank", 32'(display_bank), 32'h1);
    chk("withdrawn_ack", 32'(swap_ack), 32'h0);
    idle(LAT, 1'b0);

    // Random traffic with occasional frame boundaries and requests
    req_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) req_r = ~req_r;
      if ($urandom_range(0, 7) == 0) begin
        cyc(1'b1, 63, 15, 6'b000001, req_r);
      end else begin
        col = $urandom_range(0, 63);
        row = $urandom_range(0, 15);
        msk = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
        cyc($urandom_range(0, 3) != 0, col, row, msk, req_r);
      end
    end
    idle(LAT + 1, 1'b0);

    // Reset while a swap is pending and pixels are in flight
    if (!m_bank) begin
      cyc(1'b1, 63, 15, 6'b000001, 1'b1);
      idle(1, 1'b0);
    end
    chk("bank_before_reset", 32'(display_bank), 32'h1);
    cyc(1'b1, 10, 4, 6'b001000, 1'b1);
    cyc(1'b1, 11, 4, 6'b001000, 1'b1);
    #1;
    do_reset(2);
    chk("reset_bank", 32'(display_bank), 32'h0);
    chk("reset_valid", 32'(rgb_valid), 32'h0);
    idle(LAT + 1, 1'b0);
    for (int c = 0; c < 8; c++) cyc(1'b1, c, 15, 6'b010000, 1'b0);
    idle(LAT + 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
